// File: rtl/simon_cipher_sched_pkg.sv
// ============================================================================
// Module      : simon_pkg
// Description : Shared constants, state encoding and round/key helpers for
//               the Simon 32/64 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

    localparam logic [15:0] c_simon_c = 16'hFFFC;
    // Bit j (LSB = 0) is element j of the z0 sequence.
    localparam logic [61:0] c_z0 =
        62'b01100111000011010100100010111110110011100001101010010001011111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_KEYEXP = 2'd1;
    localparam state_t ST_RUN    = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    function automatic logic [15:0] f(input logic [15:0] x);
        return ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
    endfunction

    function automatic logic [15:0] key_step(
        input logic [15:0] k_im1,
        input logic [15:0] k_im3,
        input logic [15:0] k_im4,
        input logic        zbit
    );
        logic [15:0] t;
        t = {k_im1[2:0], k_im1[15:3]} ^ k_im3;
        t = t ^ {t[0], t[15:1]};
        return k_im4 ^ t ^ c_simon_c ^ {15'd0, zbit};
    endfunction

endpackage

`default_nettype wire

// File: rtl/simon_cipher_sched_round.sv
// ============================================================================
// Module      : simon_round
// Description : One combinational Simon 32/64 Feistel round.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_round
    import simon_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] k,
    output logic [15:0] x_next,
    output logic [15:0] y_next
);

    assign x_next = y ^ f(x) ^ k;
    assign y_next = x;

endmodule

`default_nettype wire

// File: rtl/simon_cipher_sched.sv
// ============================================================================
// Module      : simon_cipher_sched
// Description : Simon 32/64 key-expansion and block sequencer with a shared
//               round-key file. Optional SIMON_DECRYPT_EN adds a dec input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_cipher_sched
    import simon_pkg::*;
#(
    parameter int N_ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic [31:0] pt_in,
`ifdef SIMON_DECRYPT_EN
    input  logic        dec,
`endif
    output logic        ct_valid,
    input  logic        ct_ready,
    output logic [31:0] ct_out,
    output logic        key_ok,
    output logic        busy
);

    localparam logic [4:0] c_last = 5'(N_ROUNDS - 1);

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_key [0:31];
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic        r_key_ok;
    logic        r_ct_valid;
    logic [31:0] r_ct_out;
    logic        w_dec;
    logic        w_dec_in;
    logic [4:0]  w_kidx;
    logic [5:0]  w_zidx;
    logic [15:0] w_newk;
    logic [15:0] w_xn;
    logic [15:0] w_yn;
    logic        w_key_acc;
    logic        w_pt_acc;

`ifdef SIMON_DECRYPT_EN
    logic r_dec;
    assign w_dec    = r_dec;
    assign w_dec_in = dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dec <= 1'b0;
        else if (w_pt_acc)
            r_dec <= dec;
    end
`else
    assign w_dec    = 1'b0;
    assign w_dec_in = 1'b0;
`endif

    assign key_ready = (r_state == ST_IDLE);
    assign pt_ready  = (r_state == ST_IDLE) & r_key_ok & ~key_valid;
    assign busy      = (r_state != ST_IDLE);
    assign key_ok    = r_key_ok;
    assign ct_valid  = r_ct_valid;
    assign ct_out    = r_ct_out;

    assign w_key_acc = (r_state == ST_IDLE) & key_valid;
    assign w_pt_acc  = pt_valid & pt_ready;

    // Decryption walks the stored schedule backwards.
    assign w_kidx = w_dec ? (c_last - r_cnt) : r_cnt;
    assign w_zidx = {1'b0, r_cnt} - 6'd4;
    assign w_newk = key_step(r_key[r_cnt - 5'd1], r_key[r_cnt - 5'd3],
                             r_key[r_cnt - 5'd4], c_z0[w_zidx]);

    simon_round u_round (
        .x      (r_x),
        .y      (r_y),
        .k      (r_key[w_kidx]),
        .x_next (w_xn),
        .y_next (w_yn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_key[i] <= 16'd0;
        end else if (w_key_acc) begin
            r_key[0] <= key_in[15:0];
            r_key[1] <= key_in[31:16];
            r_key[2] <= key_in[47:32];
            r_key[3] <= key_in[63:48];
        end else if (r_state == ST_KEYEXP) begin
            r_key[r_cnt] <= w_newk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 5'd0;
            r_x        <= 16'd0;
            r_y        <= 16'd0;
            r_key_ok   <= 1'b0;
            r_ct_valid <= 1'b0;
            r_ct_out   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_key_acc) begin
                        r_key_ok <= 1'b0;
                        r_cnt    <= 5'd4;
                        r_state  <= ST_KEYEXP;
                    end else if (w_pt_acc) begin
                        r_x     <= w_dec_in ? pt_in[15:0]  : pt_in[31:16];
                        r_y     <= w_dec_in ? pt_in[31:16] : pt_in[15:0];
                        r_cnt   <= 5'd0;
                        r_state <= ST_RUN;
                    end
                end
                ST_KEYEXP: begin
                    if (r_cnt == c_last) begin
                        r_key_ok <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_RUN: begin
                    r_x <= w_xn;
                    r_y <= w_yn;
                    if (r_cnt == c_last) begin
                        r_ct_out   <= w_dec ? {w_yn, w_xn} : {w_xn, w_yn};
                        r_ct_valid <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (ct_ready) begin
                        r_ct_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simon_cipher_sched.sv
// ============================================================================
// Module      : tb_simon_cipher_sched
// Description : Directed self-checking bench with a cycle-level reference
//               model of the Simon 32/64 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simon_cipher_sched;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_in;
    logic        pt_valid;
    logic        pt_ready;
    logic [31:0] pt_in;
    logic        dec;
    logic        ct_valid;
    logic        ct_ready;
    logic [31:0] ct_out;
    logic        key_ok;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference state: 0 idle, 1 key expansion, 2 rounds, 3 result held.
    int          m_phase;
    int          m_left;
    bit          m_key_ok;
    logic [63:0] m_key;
    logic [63:0] m_keybuf;
    logic [31:0] exp_ct;

    always #5 clk = ~clk;

    simon_cipher_sched #(.N_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .pt_in     (pt_in),
`ifdef SIMON_DECRYPT_EN
        .dec       (dec),
`endif
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .ct_out    (ct_out),
        .key_ok    (key_ok),
        .busy      (busy)
    );

    function automatic logic [15:0] ror(input logic [15:0] v, input int n);
        logic [31:0] w;
        w = {v, v} >> n;
        return w[15:0];
    endfunction

    function automatic logic [15:0] rol(input logic [15:0] v, input int n);
        return ror(v, 16 - n);
    endfunction

    function automatic logic [31:0] model(input logic [63:0] key,
                                          input logic [31:0] blk, input bit d);
        logic [15:0] k [NR];
        logic [15:0] t, x, y, tmp;
        string z;
        int ri;
        z = "11111010001001010110000111001101111101000100101011000011100110";
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < NR; i++) begin
            t = ror(k[i-1], 3) ^ k[i-3];
            t = t ^ ror(t, 1);
            k[i] = k[i-4] ^ t ^ 16'hFFFC ^ ((z[i-4] == "1") ? 16'd1 : 16'd0);
        end
        x = d ? blk[15:0] : blk[31:16];
        y = d ? blk[31:16] : blk[15:0];
        for (int r = 0; r < NR; r++) begin
            ri  = d ? NR - 1 - r : r;
            tmp = x;
            x   = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[ri];
            y   = tmp;
        end
        return d ? {y, x} : {x, y};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Advance one clock, update the reference, then compare every output.
    task automatic step();
        if (rst) begin
            m_phase  = 0;
            m_key_ok = 1'b0;
        end else begin
            case (m_phase)
                0: if (key_valid) begin
                       m_phase = 1; m_left = NR - 4; m_key_ok = 1'b0; m_keybuf = key_in;
                   end else if (pt_valid && m_key_ok) begin
                       m_phase = 2; m_left = NR; exp_ct = model(m_key, pt_in, dec);
                   end
                1: begin
                       m_left--;
                       if (m_left == 0) begin m_phase = 0; m_key_ok = 1'b1; m_key = m_keybuf; end
                   end
                2: begin
                       m_left--;
                       if (m_left == 0) m_phase = 3;
                   end
                default: if (ct_ready) m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("key_ready", 64'(key_ready), 64'(m_phase == 0));
        chk("pt_ready", 64'(pt_ready), 64'(m_phase == 0 && m_key_ok && !key_valid));
        chk("key_ok", 64'(key_ok), 64'(m_key_ok));
        chk("ct_valid", 64'(ct_valid), 64'(m_phase == 3));
        if (m_phase == 3) chk("ct_out", 64'(ct_out), 64'(exp_ct));
    endtask

    task automatic load_key(input logic [63:0] k);
        int n;
        key_in    = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        chk("key_ready_drop", 64'(key_ready), 64'd0);
        n = 0;
        while (!key_ok && n < 200) begin
            step();
            n++;
        end
        chk("key_ok_latency", 64'(n), 64'(NR - 4));
    endtask

    task automatic run_block(input logic [31:0] blk, input logic d, input int hold,
                             output logic [31:0] res);
        int n;
        logic [31:0] held;
        pt_in    = blk;
        dec      = d;
        pt_valid = 1'b1;
        n = 0;
        while (!pt_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("pt_ready_timeout", 64'(pt_ready), 64'd1);
        step();
        pt_valid = 1'b0;
        n = 0;
        while (!ct_valid && n < 200) begin
            step();
            n++;
        end
        chk("ct_latency", 64'(n), 64'(NR));
        held = ct_out;
        for (int i = 0; i < hold; i++) begin
            key_valid = 1'b1;
            key_in    = 64'hDEAD_BEEF_0000_FFFF;
            pt_valid  = 1'b1;
            step();
            chk("ct_hold_stable", 64'(ct_out), 64'(held));
            chk("key_ready_in_done", 64'(key_ready), 64'd0);
        end
        key_valid = 1'b0;
        pt_valid  = 1'b0;
        res       = ct_out;
        ct_ready  = 1'b1;
        step();
        ct_ready  = 1'b0;
        chk("ct_valid_drop", 64'(ct_valid), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    localparam logic [63:0] K1 = 64'h1918111009080100;
    localparam logic [63:0] K2 = 64'h0123456789ABCDEF;
    localparam logic [31:0] P1 = 32'h65656877;
    localparam logic [31:0] P2 = 32'h12345678;

    initial begin
        logic [31:0] res;
        rst = 1'b1; key_valid = 1'b0; key_in = '0; pt_valid = 1'b0; pt_in = '0;
        dec = 1'b0; ct_ready = 1'b0;
        m_phase = 0; m_left = 0; m_key_ok = 1'b0; m_key = '0; m_keybuf = '0; exp_ct = '0;

        chk("model_pin_enc", 64'(model(K1, P1, 1'b0)), 64'h00000000C69BE9BB);
        chk("model_pin_dec", 64'(model(K1, 32'hC69BE9BB, 1'b1)), 64'h0000000065656877);

        #1;
        chk("rst_ct_out", 64'(ct_out), 64'd0);
        chk("rst_ct_valid", 64'(ct_valid), 64'd0);
        chk("rst_key_ok", 64'(key_ok), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Block offered with no schedule: must be ignored.
        pt_in = P1; pt_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        pt_valid = 1'b0;
        step();

        load_key(K1);
        run_block(P1, 1'b0, 0, res);
        chk("ct_vector", 64'(res), 64'h00000000C69BE9BB);
        run_block(P1, 1'b0, 5, res);
        chk("ct_vector_held", 64'(res), 64'h00000000C69BE9BB);
        chk("key_ok_persist", 64'(key_ok), 64'd1);

        // Key and block together: the key wins, the block waits.
        pt_in = P1; pt_valid = 1'b1;
        load_key(K2);
        run_block(P1, 1'b0, 0, res);
        chk("ct_key2", 64'(res), 64'(model(K2, P1, 1'b0)));

        // Reset in the middle of round processing.
        pt_in = P2; pt_valid = 1'b1;
        while (!pt_ready) step();
        step();
        pt_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_ct_valid", 64'(ct_valid), 64'd0);
        chk("arst_key_ok", 64'(key_ok), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        step();
        rst = 1'b0;
        step();
        load_key(K1);
        run_block(P2, 1'b0, 0, res);
        chk("ct_after_reset", 64'(res), 64'(model(K1, P2, 1'b0)));

`ifdef SIMON_DECRYPT_EN
        run_block(32'hC69BE9BB, 1'b1, 0, res);
        chk("dec_vector", 64'(res), 64'h0000000065656877);
        run_block(P1, 1'b0, 0, res);
        chk("b2b_enc_vector", 64'(res), 64'h00000000C69BE9BB);
        chk("b2b_key_ok", 64'(key_ok), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/simon_cipher_sched.md
Name: simon_cipher_sched

Overview:
Sequencer for the Simon 32/64 engine: one shared 32x16 round-key register file, one iterative round datapath.
- Accepts a 64-bit key on a load handshake and expands it one round key per cycle.
- Then accepts 32-bit plaintext blocks and runs the rounds one per cycle, reusing the stored schedule until a new key arrives.
- Sits between the host-side stream interface and the ciphertext consumer; it owns key-schedule validity and mutual exclusion of key load against block processing.

Parameters:
N_ROUNDS, 32, number of rounds and round keys; legal range 5..32; key expansion produces words k[4]..k[N_ROUNDS-1].

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
key_valid  in  1  key offered
key_ready  out  1  key accepted when key_valid & key_ready
key_in  in  64  k[0]=key_in[15:0], k[1]=[31:16], k[2]=[47:32], k[3]=[63:48]
pt_valid  in  1  block offered
pt_ready  out  1  block accepted when pt_valid & pt_ready
pt_in  in  32  x=pt_in[31:16], y=pt_in[15:0]
ct_valid  out  1  result available
ct_ready  in  1  consumer accepts
ct_out  out  32  {x,y} after final round
key_ok  out  1  schedule complete and usable
busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, key_ok=0, ct_valid=0, ct_out=0, round counter=0, key file cleared to 0; an in-flight expansion or block is abandoned.
- States: IDLE, KEYEXP, RUN, DONE.
- IDLE:
  - key_ready=1 always.
  - pt_ready=key_ok & ~key_valid; a key offered in the same cycle as a block takes priority and the block waits.
  - Key accept: write k[0..3], clear key_ok, counter=4, go KEYEXP.
  - Block accept: latch x,y, counter=0, go RUN.
- KEYEXP:
  - Each cycle compute k[i], i=counter: t=ror(k[i-1],3)^k[i-3]; t=t^ror(t,1); k[i]=k[i-4]^t^C^Z0[(i-4)] with C=16'hFFFC.
  - Z0=62'b01100111000011010100100010111110110011100001101010010001011111, bit j (LSB=0) is z0 sequence index j.
  - At i=N_ROUNDS-1, set key_ok=1 and go IDLE.
  - Expansion takes N_ROUNDS-4 cycles (28 at default); key_ready and pt_ready are 0 throughout.
- RUN:
  - Each cycle round r=counter: f(x)=(rol(x,1)&rol(x,8))^rol(x,2); x'=y^f(x)^k[r]; y'=x.
  - After r=N_ROUNDS-1, load ct_out={x,y}, set ct_valid=1, go DONE.
  - Latency from accept edge to ct_valid high is N_ROUNDS cycles (32).
- DONE:
  - ct_valid and ct_out are held stable until ct_ready.
  - On the accept edge: ct_valid=0, go IDLE. The next block can be accepted one cycle later; there is no overlap.
- key_ready and pt_ready are 0 outside IDLE; inputs offered then are ignored, not queued.
- key_ok persists across any number of blocks; only reset or a new key load clears it.
- Rotations are modulo 16; all XOR arithmetic is 16-bit, with no carries.

Optional Feature:
SIMON_DECRYPT_EN: adds input port dec (1 bit), sampled with each accepted block.
- With dec=1, decrypt: swap the halves on load (x=pt_in[15:0], y=pt_in[31:16]), apply rounds with k[N_ROUNDS-1-r], and swap the halves into ct_out.
- With dec=0, or when the macro is undefined, encrypt only and the port is absent.

Decomposition:
- Package simon_pkg: C constant, Z0 constant, state enum typedef (IDLE/KEYEXP/RUN/DONE), functions f(x) and key_step(k_im1,k_im3,k_im4,zbit).
- Natural sub-module: simon_round, a combinational single round (x,y,k -> x',y'); the FSM, counter and key file stay in the top.

Test Plan:
- Load key 64'h1918111009080100 -> key_ready drops; key_ok rises exactly 28 cycles after the accept edge.
- Then pt 32'h65656877 -> ct_out=32'hC69BE9BB, ct_valid 32 cycles after acceptance.
- Same pt with ct_ready held low for 5 cycles -> ct_out stable, pt_ready=0, key_ready=0 until the accept, then IDLE.
- pt_valid asserted before any key load -> pt_ready stays 0, no state change; pt_valid and key_valid together in IDLE -> key accepted, pt waits.
- Assert rst during RUN round 10 -> ct_valid=0, key_ok=0, busy=0 immediately; after release a fresh key plus pt gives correct ct.
- With SIMON_DECRYPT_EN, dec=1, pt 32'hC69BE9BB -> ct_out=32'h65656877; two back-to-back blocks reuse the schedule without re-expansion.
